// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter
// Purpose  : Round-robin arbiter sharing the single register-file write port
//            between NUM_REQ writeback requesters. The granted destination
//            address is decoded into registered one-hot write enables that
//            drive the register file's enabled flip-flop banks. Writes to the
//            hard-wired zero register are accepted and then discarded.
// Ports    : clk_i          - system clock, rising edge
//            reset_i        - synchronous active-high reset
//            req_valid_i    - per-requester write request
//            req_addr_i     - packed destination addresses (k*ADDR_W +: ADDR_W)
//            req_data_i     - packed write data (k*DATA_W +: DATA_W)
//            req_ready_o    - combinational one-hot grant/accept
//            wr_enable_o    - registered one-hot register write enables
//            wr_data_o      - registered write data
//            grant_id_o     - registered index of last accepted requester
//            conflict_cnt_o - saturating count of multi-request cycles
// Revision : 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 64,
    parameter int ZERO_REG = 31
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [NUM_REGS-1:0]       wr_enable_o,
    output logic [DATA_W-1:0]         wr_data_o,
    output logic [1:0]                grant_id_o,
    output logic [15:0]               conflict_cnt_o
);

    localparam int                PTR_W      = $clog2(NUM_REQ);
    localparam logic [NUM_REGS-1:0] c_onehot_lsb = {{(NUM_REGS-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_zero_reg = ADDR_W'(ZERO_REG);
    localparam logic [15:0]       c_cnt_max  = 16'hFFFF;

    // (base + off) mod NUM_REQ; base and off are both below NUM_REQ, so one
    // conditional subtract is enough even for non-power-of-two NUM_REQ.
    function automatic logic [PTR_W-1:0] wrap_idx(input int unsigned base,
                                                  input int unsigned off);
        int unsigned s;
        s = base + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return s[PTR_W-1:0];
    endfunction

    logic [PTR_W-1:0]  r_rr_ptr;
    logic [NUM_REGS-1:0] r_wr_enable;
    logic [DATA_W-1:0] r_wr_data;
    logic [1:0]        r_grant_id;
    logic [15:0]       r_conflict_cnt;

    logic [NUM_REQ-1:0] w_ready;
    logic               w_accept;
    logic [PTR_W-1:0]   w_grant_idx;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_conflict;

    logic [ADDR_W-1:0] w_addr [NUM_REQ];
    logic [DATA_W-1:0] w_data [NUM_REQ];

    generate
        for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
            assign w_addr[k] = req_addr_i[k*ADDR_W +: ADDR_W];
            assign w_data[k] = req_data_i[k*DATA_W +: DATA_W];
        end
    endgenerate

    // Scan from the round-robin pointer; the first valid requester wins.
    // Reset suppresses all grants so nothing is accepted while in reset.
    always_comb begin
        w_ready     = '0;
        w_accept    = 1'b0;
        w_grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_accept && req_valid_i[wrap_idx(int'(r_rr_ptr), i)]) begin
                w_accept    = 1'b1;
                w_grant_idx = wrap_idx(int'(r_rr_ptr), i);
            end
        end
        if (reset_i) begin
            w_accept = 1'b0;
        end
        if (w_accept) begin
            w_ready[w_grant_idx] = 1'b1;
        end
    end

    assign w_sel_addr = w_addr[w_grant_idx];
    assign w_sel_data = w_data[w_grant_idx];
    assign w_conflict = ($countones(req_valid_i) >= 2);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rr_ptr       <= '0;
            r_wr_enable    <= '0;
            r_wr_data      <= '0;
            r_grant_id     <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_rr_ptr   <= wrap_idx(int'(w_grant_idx), 1);
                r_wr_data  <= w_sel_data;
                r_grant_id <= 2'(w_grant_idx);
                // Zero-register writes complete the handshake but never
                // reach the register file.
                r_wr_enable <= (w_sel_addr != c_zero_reg) ?
                               (c_onehot_lsb << w_sel_addr) : '0;
            end else begin
                r_wr_enable <= '0;
            end

            if (w_conflict && (r_conflict_cnt != c_cnt_max)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
        end
    end

    assign req_ready_o    = w_ready;
    assign wr_enable_o    = r_wr_enable;
    assign wr_data_o      = r_wr_data;
    assign grant_id_o     = r_grant_id;
    assign conflict_cnt_o = r_conflict_cnt;

endmodule
`default_nettype wire

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Round-robin arbiter that shares the single register-file write port between NUM_REQ writeback requesters (e.g. ALU writeback and load unit).
- Decodes the granted destination address into one-hot per-register write enables. These drive the enable_i pins of the register file's enabled flip-flop banks.
- Sits between the writeback stage and the register file.
- Writes to the hard-wired zero register are accepted and then discarded.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- NUM_REGS, 32, number of architectural registers.
- ADDR_W, 5, register address width; must satisfy 2**ADDR_W == NUM_REGS.
- DATA_W, 64, write data width.
- ZERO_REG, 31, register index that is never written.

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- reset_i  input  1  synchronous, active-high reset.
- req_valid_i  input  NUM_REQ  per-requester write request.
- req_addr_i  input  NUM_REQ*ADDR_W  destination addresses; requester k occupies bits [k*ADDR_W +: ADDR_W].
- req_data_i  input  NUM_REQ*DATA_W  write data; requester k occupies bits [k*DATA_W +: DATA_W].
- req_ready_o  output  NUM_REQ  one-hot grant/accept, combinational, same cycle.
- wr_enable_o  output  NUM_REGS  registered one-hot register write enables.
- wr_data_o  output  DATA_W  registered write data.
- grant_id_o  output  2  registered index of the requester accepted in the previous cycle.
- conflict_cnt_o  output  16  registered count of cycles with more than one valid request.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high (reset_i); there is no asynchronous reset path.

- Reset values:
  - rr_ptr = 0.
  - wr_enable_o = 0.
  - wr_data_o = 0.
  - grant_id_o = 0.
  - conflict_cnt_o = 0.
  - While reset_i is high, req_ready_o is forced to 0.

- Handshake:
  - A transfer occurs for requester k in a cycle where req_valid_i[k] && req_ready_o[k].
  - A requester holds valid, addr and data stable until accepted.
  - Deasserting valid before acceptance is allowed; the request is simply withdrawn.

- Arbitration (combinational):
  - Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first k with req_valid_i[k]=1 gets req_ready_o[k]=1; all other ready bits are 0.
  - No valid request means req_ready_o = 0.
  - At most one ready bit is high per cycle.

- Pointer update:
  - On an accept by k: rr_ptr <= (k+1) mod NUM_REQ.
  - No accept: rr_ptr holds.

- Output stage (1-cycle latency, registered):
  - Accept in cycle N with addr A != ZERO_REG: in cycle N+1, wr_enable_o = (1 << A) and wr_data_o = data. The register file captures it on the edge ending cycle N+1.
  - Accept with A == ZERO_REG: wr_enable_o = 0 in N+1. wr_data_o and grant_id_o still update; the write is discarded.
  - No accept in cycle N: wr_enable_o = 0 in N+1; wr_data_o and grant_id_o hold.
  - wr_enable_o is never high for more than one cycle per accepted request.
  - wr_enable_o is always one-hot or zero.

- Back-to-back operation: a new accept is possible every cycle; throughput is 1 write/cycle. No internal buffering beyond the single output register.

- Conflict counter:
  - Increments by 1 on any cycle where popcount(req_valid_i) >= 2 and reset_i = 0.
  - Saturates at 16'hFFFF; it does not wrap.

- Reset mid-operation: an accepted write sitting in the output register is dropped. wr_enable_o = 0 in the cycle after reset_i is sampled high.

- Address range: ADDR_W is sized so every address decodes to a valid register; there are no out-of-range addresses.

Test Plan:
1. Reset then idle: hold reset_i=1 for 2 cycles, release, keep all valid=0 -> wr_enable_o=0, req_ready_o=0, conflict_cnt_o=0, grant_id_o=0.
2. Single write: req 0 valid, addr=5, data=64'hDEAD_BEEF in cycle N -> req_ready_o=2'b01 in N; in N+1 wr_enable_o=32'h0000_0020, wr_data_o=64'hDEAD_BEEF, grant_id_o=0; in N+2 wr_enable_o=0.
3. Round-robin fairness: both requesters valid continuously for 4 cycles from reset, req0 addr=1, req1 addr=2 -> grants alternate 0,1,0,1. wr_enable_o sequence 0x2,0x4,0x2,0x4 lagging by one cycle. conflict_cnt_o=4.
4. Zero register: req 1 writes addr=31, data=64'h1 -> req_ready_o=2'b10. Next cycle wr_enable_o=0, grant_id_o=1, rr_ptr advances to 0.
5. Reset mid-operation: accept req0 addr=7 in cycle N, assert reset_i in cycle N -> wr_enable_o=0 in N+1, rr_ptr=0.
6. Counter saturation: preload or run 65536+ cycles with both requesters valid -> conflict_cnt_o stops at 16'hFFFF.
